// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: request/response channels of the two SRAM clients.
// The master side belongs to the fetch and data requesters, the slave
// side to the arbiter that owns the SRAM pins.
`timescale 1ns/1ps
interface sram_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;

  modport master (
    output i_req, i_addr,
    input  i_done, i_rdata,
    output d_req, d_we, d_funct3, d_addr, d_wdata,
    input  d_done, d_rdata
  );

  modport slave (
    input  i_req, i_addr,
    output i_done, i_rdata,
    input  d_req, d_we, d_funct3, d_addr, d_wdata,
    output d_done, d_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit asynchronous SRAM between the instruction
// fetch port (32-bit reads) and the data port (RV32 loads/stores). Every SRAM
// pin is driven from a flop; an access is one or two half-word beats, upper
// half at the even address. Round-robin arbitration on simultaneous requests.
`timescale 1ns/1ps
module sram_arbiter #(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] I_OFFSET = 20'h80000
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_arbiter_if.slave     bus,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [15:0]       o_SRAM_DQ
);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_t;

  // Registered SRAM pin bundle (address kept separately).
  typedef struct packed {
    logic        we_n;
    logic        oe_n;
    logic        lb_n;
    logic        ub_n;
    logic        dq_oe;
    logic [15:0] dq;
  } pins_t;

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam pins_t PINS_IDLE = '{we_n: 1'b1, oe_n: 1'b0, lb_n: 1'b0, ub_n: 1'b0,
                                  dq_oe: 1'b0, dq: 16'h0000};

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       hi_q, hi_d;
  pins_t             pins_q, pins_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ce_n_q;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic              take_d, take_i;
  logic [ADDR_W-1:0] i_base, d_base;
  logic [15:0]       dq_in;
  logic              fin;
  logic [31:0]       rd_val;
  logic              unused_addr_bits;

  // Pin values for one beat of the latched access; second selects the
  // lower half of a word store. Unsupported store widths write nothing.
  function automatic pins_t beat_pins(input logic we, input logic [2:0] f3,
                                      input logic [31:0] wd, input logic second);
    pins_t p;
    p = PINS_IDLE;
    if (we) begin
      p.oe_n = 1'b1;
      case (f3)
        F3_W: begin
          p.we_n  = 1'b0;
          p.dq_oe = 1'b1;
          p.dq    = second ? wd[15:0] : wd[31:16];
        end
        F3_H: begin
          p.we_n  = 1'b0;
          p.dq_oe = 1'b1;
          p.dq    = wd[15:0];
        end
        F3_B: begin
          p.we_n  = 1'b0;
          p.dq_oe = 1'b1;
          p.lb_n  = 1'b1;
          p.dq    = {wd[7:0], 8'h00};
        end
        default: p.we_n = 1'b1;
      endcase
    end
    return p;
  endfunction

  // Sub-word load extension; the addressed byte sits in the upper lane.
  function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [15:0] h);
    logic [31:0] r;
    case (f3)
      F3_B:    r = {{24{h[15]}}, h[15:8]};
      F3_BU:   r = {24'h000000, h[15:8]};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  assign d_base = ADDR_W'({bus.d_addr[18:0], 1'b0});
  assign i_base = ADDR_W'({bus.i_addr[18:0], 1'b0}) + I_OFFSET;
  assign dq_in  = o_SRAM_DQ;

  assign unused_addr_bits = &{1'b0, bus.i_addr[31:19], bus.d_addr[31:19]};

  // Data wins a tie unless it was the last one served.
  assign take_d = bus.d_req && (!bus.i_req || (last_q == OWN_I));
  assign take_i = bus.i_req && !take_d;

  // Next-state, next pin values and completion of the current access.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    base_d    = base_q;
    we_d      = we_q;
    f3_d      = f3_q;
    wdata_d   = wdata_q;
    hi_d      = hi_q;
    pins_d    = pins_q;
    addr_d    = addr_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    fin       = 1'b0;
    rd_val    = 32'h0000_0000;

    case (state_q)
      IDLE: begin
        if (take_d || take_i) begin
          state_d = BEAT1;
          owner_d = take_i ? OWN_I : OWN_D;
          last_d  = take_i ? OWN_I : OWN_D;
          base_d  = take_i ? i_base : d_base;
          we_d    = take_i ? 1'b0 : bus.d_we;
          f3_d    = take_i ? F3_W : bus.d_funct3;
          wdata_d = take_i ? 32'h0000_0000 : bus.d_wdata;
          pins_d  = beat_pins(we_d, f3_d, wdata_d, 1'b0);
          addr_d  = base_d;
        end
      end
      BEAT1: begin
        if (f3_q == F3_W) begin
          state_d = BEAT2;
          hi_d    = dq_in;
          pins_d  = beat_pins(we_q, f3_q, wdata_q, 1'b1);
          addr_d  = base_q + ADDR_W'(1);
        end else begin
          state_d = DONE;
          pins_d  = PINS_IDLE;
          fin     = 1'b1;
          rd_val  = ext_load(f3_q, dq_in);
        end
      end
      BEAT2: begin
        state_d = DONE;
        pins_d  = PINS_IDLE;
        fin     = 1'b1;
        rd_val  = {hi_q, dq_in};
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fin) begin
      if (owner_q == OWN_I) begin
        i_done_d  = 1'b1;
        i_rdata_d = rd_val;
      end else begin
        d_done_d = 1'b1;
        if (!we_q) begin
          d_rdata_d = rd_val;
        end
      end
    end
  end

  // FSM state register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched access, pin flops and requester responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_D;
      last_q    <= OWN_I;
      base_q    <= '0;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      wdata_q   <= 32'h0000_0000;
      hi_q      <= 16'h0000;
      pins_q    <= PINS_IDLE;
      addr_q    <= '0;
      ce_n_q    <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= 32'h0000_0000;
      d_rdata_q <= 32'h0000_0000;
    end else begin
      owner_q   <= owner_d;
      last_q    <= last_d;
      base_q    <= base_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      wdata_q   <= wdata_d;
      hi_q      <= hi_d;
      pins_q    <= pins_d;
      addr_q    <= addr_d;
      ce_n_q    <= 1'b0;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign o_SRAM_WE_N = pins_q.we_n;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_OE_N = pins_q.oe_n;
  assign o_SRAM_LB_N = pins_q.lb_n;
  assign o_SRAM_UB_N = pins_q.ub_n;
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_DQ   = pins_q.dq_oe ? pins_q.dq : 16'hzzzz;

  assign bus.i_done  = i_done_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_done  = d_done_q;
  assign bus.d_rdata = d_rdata_q;

endmodule
